overlap_add_accumulator: RTL and testbench



---
 rtl/overlap_add_pkg.sv | 31 +++
 rtl/overlap_add_lane.sv | 65 ++++++
 rtl/overlap_add_accumulator.sv | 106 ++++++++++
 tb/tb_overlap_add_accumulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/overlap_add_pkg.sv
// Shared sizing and arithmetic helpers for the overlap-add accumulator.
package overlap_add_pkg;

  localparam int SAT_CALC_W = 64;

  function automatic int n_pix_out(input int f, input int k, input int s);
    return (f - 1) * s + k;
  endfunction

  // Bit offset of element idx of channel ch in a bus of n elements of w bits each.
  function automatic int pack_base(input int ch, input int idx, input int n, input int w);
    return (ch * n + idx) * w;
  endfunction

  function automatic logic signed [SAT_CALC_W-1:0] sat_add(
    input logic signed [SAT_CALC_W-1:0] a,
    input logic signed [SAT_CALC_W-1:0] b,
    input int                           w
  );
    logic signed [SAT_CALC_W:0] sum;
    logic signed [SAT_CALC_W:0] hi;
    logic signed [SAT_CALC_W:0] lo;
    sum = {a[SAT_CALC_W-1], a} + {b[SAT_CALC_W-1], b};
    hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (w - 1));
    if (sum > hi) return hi[SAT_CALC_W-1:0];
    if (sum < lo) return lo[SAT_CALC_W-1:0];
    return sum[SAT_CALC_W-1:0];
  endfunction

endpackage

// File: rtl/overlap_add_lane.sv
// One channel of the overlap-add row buffer: pixel accumulators, the
// saturating adders and the clamp detect for the current segment.
module overlap_add_lane
  import overlap_add_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ACC_WIDTH     = 20,
  parameter int N_COL_FEATURE = 8,
  parameter int N_COL_KERNEL  = 5,
  parameter int NUM_STRIDE    = 2,
  parameter int BEAT_W        = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               accept,
  input  logic                               clear,
  input  logic [BEAT_W-1:0]                  beat,
  input  logic [N_COL_KERNEL*DATA_WIDTH-1:0] seg,
  output logic [n_pix_out(N_COL_FEATURE, N_COL_KERNEL, NUM_STRIDE)*ACC_WIDTH-1:0] sum_p0,
  output logic                               clamp_p0
);

  localparam int N_PIX = n_pix_out(N_COL_FEATURE, N_COL_KERNEL, NUM_STRIDE);

  logic signed [ACC_WIDTH-1:0] acc_p0 [N_PIX];
  logic signed [ACC_WIDTH-1:0] add_p0 [N_PIX];
  logic signed [ACC_WIDTH-1:0] nxt_p0 [N_PIX];
  logic        [ACC_WIDTH:0]   raw_p0 [N_PIX];
  logic        [N_PIX-1:0]     clamp_pix;

  function automatic logic signed [ACC_WIDTH-1:0] sat_pix(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    return ACC_WIDTH'(sat_add(SAT_CALC_W'(a), SAT_CALC_W'(b), ACC_WIDTH));
  endfunction

  // Pixels outside the current segment get a zero addend, which can never clamp.
  always_comb begin
    sum_p0 = '0;
    for (int j = 0; j < N_PIX; j++) begin
      add_p0[j] = '0;
      for (int i = 0; i < N_COL_KERNEL; i++) begin
        if (int'(beat) * NUM_STRIDE + i == j)
          add_p0[j] = ACC_WIDTH'($signed(seg[i*DATA_WIDTH +: DATA_WIDTH]));
      end
      raw_p0[j]    = {acc_p0[j][ACC_WIDTH-1], acc_p0[j]} + {add_p0[j][ACC_WIDTH-1], add_p0[j]};
      clamp_pix[j] = raw_p0[j][ACC_WIDTH] ^ raw_p0[j][ACC_WIDTH-1];
      nxt_p0[j]    = sat_pix(acc_p0[j], add_p0[j]);
      sum_p0[j*ACC_WIDTH +: ACC_WIDTH] = nxt_p0[j];
    end
  end

  assign clamp_p0 = |clamp_pix;

  // ---- stage p0: row accumulator ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N_PIX; j++) acc_p0[j] <= '0;
    end else if (accept) begin
      for (int j = 0; j < N_PIX; j++) acc_p0[j] <= clear ? '0 : nxt_p0[j];
    end
  end

endmodule

// File: rtl/overlap_add_accumulator.sv
// Multi-channel overlap-add accumulator: accumulates N_COL_FEATURE segments
// per row and hands the finished row out through a valid/ready register.
module overlap_add_accumulator
  import overlap_add_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ACC_WIDTH     = 20,
  parameter int N_COL_FEATURE = 8,
  parameter int N_COL_KERNEL  = 5,
  parameter int NUM_STRIDE    = 2,
  parameter int N_CH          = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [N_CH*N_COL_KERNEL*DATA_WIDTH-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [N_CH*n_pix_out(N_COL_FEATURE, N_COL_KERNEL, NUM_STRIDE)*ACC_WIDTH-1:0] out_data,
  output logic out_sat,
  output logic busy
);

  localparam int N_PIX_OUT = n_pix_out(N_COL_FEATURE, N_COL_KERNEL, NUM_STRIDE);
  localparam int SEG_W     = N_COL_KERNEL * DATA_WIDTH;
  localparam int ROW_W     = N_PIX_OUT * ACC_WIDTH;
  localparam int BEAT_W    = (N_COL_FEATURE > 1) ? $clog2(N_COL_FEATURE) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_COL_FEATURE - 1);

  logic [BEAT_W-1:0]     beat_cnt_p0;
  logic                  sat_work_p0;
  logic                  vld_p1;
  logic                  sat_p1;
  logic [N_CH*ROW_W-1:0] data_p1;
  logic [N_CH*ROW_W-1:0] lane_sum_p0;
  logic [N_CH-1:0]       lane_clamp_p0;
  logic                  last_beat;
  logic                  accept;
  logic                  row_done;
  logic                  clamp_any;

  assign last_beat = (beat_cnt_p0 == LAST_BEAT);
  // Only the closing beat needs the output register, so only it can stall.
  assign in_ready  = !last_beat || !vld_p1 || out_ready;
  assign accept    = in_valid && in_ready;
  assign row_done  = accept && last_beat;
  assign clamp_any = |lane_clamp_p0;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    overlap_add_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH),
      .N_COL_FEATURE(N_COL_FEATURE),
      .N_COL_KERNEL (N_COL_KERNEL),
      .NUM_STRIDE   (NUM_STRIDE),
      .BEAT_W       (BEAT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .accept  (accept),
      .clear   (last_beat),
      .beat    (beat_cnt_p0),
      .seg     (in_data[pack_base(c, 0, N_COL_KERNEL, DATA_WIDTH) +: SEG_W]),
      .sum_p0  (lane_sum_p0[c*ROW_W +: ROW_W]),
      .clamp_p0(lane_clamp_p0[c])
    );
  end

  // ---- stage p0: beat counter and sticky row saturation ----
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_p0 <= '0;
      sat_work_p0 <= 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        beat_cnt_p0 <= '0;
        sat_work_p0 <= 1'b0;
      end else begin
        beat_cnt_p0 <= beat_cnt_p0 + BEAT_W'(1);
        sat_work_p0 <= sat_work_p0 | clamp_any;
      end
    end
  end

  // ---- stage p1: completed-row output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sat_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (row_done) begin
      vld_p1  <= 1'b1;
      sat_p1  <= sat_work_p0 | clamp_any;
      data_p1 <= lane_sum_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_sat   = sat_p1;
  assign out_data  = data_p1;
  assign busy      = (beat_cnt_p0 != '0);

endmodule

// File: tb/tb_overlap_add_accumulator.sv
// Directed bench: default config, a 16-bit accumulator variant and two
// dual-channel variants (stride 5 and stride 1) driven from a shared handshake.
module tb_overlap_add_accumulator;

  localparam int DW = 16;
  localparam int K  = 5;
  localparam int F  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid;
  logic               out_ready;
  logic [2*K*DW-1:0]  in_data;

  logic rdy_d, vld_d, sat_d, busy_d;
  logic [19*20-1:0] od_d;
  logic rdy_a, vld_a, sat_a, busy_a;
  logic [19*16-1:0] od_a;
  logic rdy_5, vld_5, sat_5, busy_5;
  logic [2*40*20-1:0] od_5;
  logic rdy_1, vld_1, sat_1, busy_1;
  logic [2*12*20-1:0] od_1;

  int tests = 0;
  int fails = 0;

  overlap_add_accumulator u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d),
    .in_data(in_data[K*DW-1:0]), .out_valid(vld_d), .out_ready(out_ready),
    .out_data(od_d), .out_sat(sat_d), .busy(busy_d)
  );

  overlap_add_accumulator #(.ACC_WIDTH(16)) u_a16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data[K*DW-1:0]), .out_valid(vld_a), .out_ready(out_ready),
    .out_data(od_a), .out_sat(sat_a), .busy(busy_a)
  );

  overlap_add_accumulator #(.NUM_STRIDE(5), .N_CH(2)) u_s5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_5),
    .in_data(in_data), .out_valid(vld_5), .out_ready(out_ready),
    .out_data(od_5), .out_sat(sat_5), .busy(busy_5)
  );

  overlap_add_accumulator #(.NUM_STRIDE(1), .N_CH(2)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_1),
    .in_data(in_data), .out_valid(vld_1), .out_ready(out_ready),
    .out_data(od_1), .out_sat(sat_1), .busy(busy_1)
  );

  function automatic longint pd(input int j);
    return longint'($signed(od_d[j*20 +: 20]));
  endfunction

  function automatic longint pa(input int j);
    return longint'($signed(od_a[j*16 +: 16]));
  endfunction

  function automatic longint p5(input int c, input int j);
    return longint'($signed(od_5[(c*40+j)*20 +: 20]));
  endfunction

  function automatic longint p1(input int c, input int j);
    return longint'($signed(od_1[(c*12+j)*20 +: 20]));
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [15:0] v0, input logic [15:0] v1);
    for (int i = 0; i < K; i++) begin
      in_data[i*DW +: DW]     = v0;
      in_data[(K+i)*DW +: DW] = v1;
    end
  endtask

  task automatic set_ramp(input int k, input int off1);
    for (int i = 0; i < K; i++) begin
      in_data[i*DW +: DW]     = 16'(k*10 + i);
      in_data[(K+i)*DW +: DW] = 16'(off1 + k*10 + i);
    end
  endtask

  task automatic send_beat();
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    while (!rdy_d && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) chk("beat_accept_timeout", 0, 1);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic send_row(input logic [15:0] v0, input logic [15:0] v1);
    set_all(v0, v1);
    for (int k = 0; k < F; k++) send_beat();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     ones[19] = '{1,1,2,2,3,2,3,2,3,2,3,2,3,2,3,2,2,1,1};
    longint model[19];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_out_valid", longint'(vld_d), 0);
    chk("rst_in_ready", longint'(rdy_d), 1);
    chk("rst_busy", longint'(busy_d), 0);
    chk("rst_out_sat", longint'(sat_d), 0);
    chk("rst_out_data", longint'(|od_d), 0);

    // all ones, continuous valid
    set_all(16'd1, 16'd1);
    for (int k = 0; k < F-1; k++) send_beat();
    chk("ones_valid_early", longint'(vld_d), 0);
    chk("ones_busy", longint'(busy_d), 1);
    send_beat();
    chk("ones_valid", longint'(vld_d), 1);
    for (int j = 0; j < 19; j++) chk($sformatf("ones_pix%0d", j), pd(j), longint'(ones[j]));
    chk("ones_sat", longint'(sat_d), 0);
    chk("ones_busy_after", longint'(busy_d), 0);
    tick();
    chk("ones_drained", longint'(vld_d), 0);
    chk("ones_hold", pd(4), 3);

    // saturation
    send_row(16'h7FFF, 16'h7FFF);
    chk("pos_pix4", pd(4), 64'h17FFD);
    chk("pos_sat", longint'(sat_d), 0);
    send_row(16'h8000, 16'h8000);
    chk("neg16_pix0", pa(0), -32768);
    chk("neg16_pix4", pa(4), -32768);
    chk("neg16_pix18", pa(18), -32768);
    chk("neg16_sat", longint'(sat_a), 1);
    chk("neg16_valid", longint'(vld_a), 1);
    chk("neg16_busy", longint'(busy_a), 0);
    chk("neg16_ready", longint'(rdy_a), 1);
    chk("neg20_pix4", pd(4), -98304);
    chk("neg20_sat", longint'(sat_d), 0);
    tick();

    // backpressure: row 1 ones, row 2 twos
    out_ready = 1'b0;
    send_row(16'd1, 16'd1);
    chk("bp_row1_valid", longint'(vld_d), 1);
    set_all(16'd2, 16'd2);
    for (int k = 0; k < F-1; k++) send_beat();
    chk("bp_row2_busy", longint'(busy_d), 1);
    in_valid = 1'b1;
    #1;
    chk("bp_stall_ready", longint'(rdy_d), 0);
    tick();
    chk("bp_hold_valid", longint'(vld_d), 1);
    chk("bp_hold_pix4", pd(4), 3);
    chk("bp_hold_busy", longint'(busy_d), 1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", longint'(rdy_d), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_swap_valid", longint'(vld_d), 1);
    chk("bp_swap_pix4", pd(4), 6);
    chk("bp_swap_pix0", pd(0), 2);
    chk("bp_swap_busy", longint'(busy_d), 0);
    tick();
    chk("bp_drained", longint'(vld_d), 0);
    chk("bp_data_hold", pd(4), 6);

    // reset mid-row
    set_all(16'h0100, 16'h0100);
    for (int k = 0; k < 3; k++) send_beat();
    chk("mid_busy", longint'(busy_d), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", longint'(busy_d), 0);
    chk("mid_rst_valid", longint'(vld_d), 0);
    chk("mid_rst_data", longint'(|od_d), 0);
    set_all(16'd1, 16'd1);
    for (int k = 0; k < F-1; k++) send_beat();
    chk("mid_valid_early", longint'(vld_d), 0);
    chk("mid_data_early", longint'(|od_d), 0);
    send_beat();
    chk("mid_valid", longint'(vld_d), 1);
    for (int j = 0; j < 19; j++) chk($sformatf("mid_pix%0d", j), pd(j), longint'(ones[j]));
    chk("mid_sat", longint'(sat_d), 0);
    tick();

    // ramp with random idle gaps
    for (int j = 0; j < 19; j++) model[j] = 0;
    for (int k = 0; k < F; k++)
      for (int i = 0; i < K; i++) model[k*2+i] += longint'(k*10 + i);
    for (int k = 0; k < F; k++) begin
      for (int g = 0; g < 10 && $urandom_range(0, 99) < 30; g++) tick();
      set_ramp(k, 0);
      send_beat();
    end
    chk("ramp_valid", longint'(vld_d), 1);
    for (int j = 0; j < 19; j++) chk($sformatf("ramp_pix%0d", j), pd(j), model[j]);
    tick();

    // two channels, stride 5: plain concatenation of segments
    for (int k = 0; k < F; k++) begin
      set_ramp(k, 100);
      send_beat();
    end
    chk("s5_valid", longint'(vld_5), 1);
    chk("s5_c0_pix0", p5(0, 0), 0);
    chk("s5_c0_pix7", p5(0, 7), 12);
    chk("s5_c0_pix39", p5(0, 39), 74);
    chk("s5_c1_pix20", p5(1, 20), 140);
    chk("s5_c1_pix39", p5(1, 39), 174);
    chk("s5_sat", longint'(sat_5), 0);
    chk("s5_busy", longint'(busy_5), 0);
    chk("s5_ready", longint'(rdy_5), 1);
    tick();

    // two channels, stride 1
    send_row(16'd1, 16'd2);
    chk("s1_valid", longint'(vld_1), 1);
    chk("s1_c0_pix4", p1(0, 4), 5);
    chk("s1_c1_pix4", p1(1, 4), 10);
    chk("s1_c0_pix0", p1(0, 0), 1);
    chk("s1_c1_pix11", p1(1, 11), 2);
    chk("s1_sat", longint'(sat_1), 0);
    chk("s1_busy", longint'(busy_1), 0);
    chk("s1_ready", longint'(rdy_1), 1);
    tick();
    chk("s1_drained", longint'(vld_1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
